uart_tx_arbiter: RTL

Round-robin arbiter that shares one `uart_tx` byte transmitter among `N_REQ` independent requesters. Each requester offers one byte at a time on a valid/ready port. The arbiter picks a winner, captures its byte, and issues a single-cycle `tx_start`. It then tracks `tx_busy` through the transmission and enforces a guard interval before the next byte is issued. It sits between the system's byte producers (debug console, status reporter, etc.) and the `uart_tx` instance.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 40 ++++
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and default baud timing.
// Used by uart_tx_arbiter and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GUARD
  } arb_state_e;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned BAUD_RATE  = 9600;
  // One bit period in clocks; also the default stop-bit guard after each byte.
  localparam int unsigned BIT_PERIOD = CLK_FREQ / BAUD_RATE;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and the uart_tx.
// Optional macro UART_TX_ARB_LOCK_EN adds the req_last message-framing bits.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*8-1:0]       req_data;
  logic [N_REQ-1:0]         req_ready;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N_REQ-1:0]         req_last;
`endif
  logic                     tx_start;
  logic [7:0]               tx_data;
  logic                     tx_busy;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic                     arb_busy;
  logic                     err_timeout;

  // Requesters plus the uart_tx side, as seen from outside the arbiter.
  modport master (
    output req_valid, req_data,
`ifdef UART_TX_ARB_LOCK_EN
    output req_last,
`endif
    output tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, arb_busy, err_timeout
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  req_last,
`endif
    input  tx_busy,
    output req_ready, tx_start, tx_data, grant_id, arb_busy, err_timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;
  logic          found;

  // Walk candidates ptr+1 .. ptr+N and keep the first one that is requesting.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// Optional macro UART_TX_ARB_LOCK_EN: keep the grant on one requester until
// it sends a byte flagged req_last, so messages are never interleaved.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          N_REQ         = 4,
  parameter int unsigned GUARD_CYCLES  = BIT_PERIOD,
  parameter int unsigned START_TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    grant_id_q, grant_id_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [31:0]      cnt_q, cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
  logic             lock_q, lock_d;
`endif

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] req_ready;
  logic             tx_start;
  logic             err_timeout;

  // Nobody is eligible while uart_tx is busy; under lock only the owner is.
  always_comb begin
    elig = bus.req_valid & {N_REQ{~bus.tx_busy}};
`ifdef UART_TX_ARB_LOCK_EN
    if (lock_q) begin
      elig = elig & ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q);
    end
`endif
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State, pointer, captured byte and shared timeout/guard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N_REQ - 1);
      grant_id_q <= '0;
      tx_data_q  <= 8'h00;
      cnt_q      <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  // Next-state and pulse outputs: grant in IDLE, start, wait busy, wait done, guard.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    req_ready   = '0;
    tx_start    = 1'b0;
    err_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready  = pick_gnt;
          tx_data_d  = bus.req_data[int'(pick_idx)*8 +: 8];
          grant_id_d = pick_idx;
          ptr_d      = pick_idx;
`ifdef UART_TX_ARB_LOCK_EN
          lock_d     = ~bus.req_last[pick_idx];
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q + 32'd1 >= START_TIMEOUT) begin
          err_timeout = 1'b1;
          cnt_d       = GUARD_CYCLES;
          state_d     = GUARD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_d   = GUARD_CYCLES;
          state_d = GUARD;
        end
      end
      GUARD: begin
        // Leaving at 1 gives exactly GUARD_CYCLES cycles; a zero load still takes one.
        if (cnt_q <= 32'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = req_ready;
  assign bus.tx_start    = tx_start;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.arb_busy    = (state_q != IDLE);
  assign bus.err_timeout = err_timeout;

endmodule
